// File: rtl/pc_redirect.sv
// -----------------------------------------------------------------------------
// pc_redirect
//
// Control-flow redirect stage in front of the program counter. Collects branch,
// jump, interrupt and return-from-interrupt requests, picks one by priority,
// and drives the counter with a registered one-cycle load pulse. Each accepted
// redirect also opens a flush window of FLUSH_CYCLES cycles. The stage holds
// the saved exception PC and the interrupt-enable bit.
//
// Parameters
//   FLUSH_CYCLES  flush window length per redirect (1..15)
//   IRQ_VECTOR    interrupt entry address
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   ex_pc       in   PC of the instruction in execute (saved on irq entry)
//   br_valid    in   branch resolved this cycle
//   br_taken    in   branch outcome
//   br_target   in   branch target
//   jmp_valid   in   unconditional jump this cycle
//   jmp_target  in   jump target
//   eret        in   return from interrupt
//   irq         in   level-sensitive interrupt request
//   load        out  one-cycle load pulse to the counter
//   load_val    out  load value, holds last target
//   flush       out  squash younger stages
//   irq_ack     out  one-cycle pulse on interrupt entry
//   epc         out  saved exception PC
//   irq_en      out  interrupts enabled
// -----------------------------------------------------------------------------
module pc_redirect #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        eret,
    input  logic        irq,
    output logic        load,
    output logic [31:0] load_val,
    output logic        flush,
    output logic        irq_ack,
    output logic [31:0] epc,
    output logic        irq_en
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES);

    state_t      r_state;
    logic [3:0]  r_fcnt;
    logic        r_load;
    logic [31:0] r_load_val;
    logic        r_flush;
    logic        r_irq_ack;
    logic [31:0] r_epc;
    logic        r_irq_en;

    state_t      w_state_nxt;
    logic [3:0]  w_fcnt_nxt;
    logic        w_load_nxt;
    logic [31:0] w_load_val_nxt;
    logic        w_flush_nxt;
    logic        w_irq_ack_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_irq_en_nxt;
    logic        w_accept;
    logic [31:0] w_target;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_fcnt     <= 4'd0;
            r_load     <= 1'b0;
            r_load_val <= 32'd0;
            r_flush    <= 1'b0;
            r_irq_ack  <= 1'b0;
            r_epc      <= 32'd0;
            r_irq_en   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_load     <= w_load_nxt;
            r_load_val <= w_load_val_nxt;
            r_flush    <= w_flush_nxt;
            r_irq_ack  <= w_irq_ack_nxt;
            r_epc      <= w_epc_nxt;
            r_irq_en   <= w_irq_en_nxt;
        end
    end

    // Next-state logic. load and irq_ack are pulses, so they default to 0;
    // everything else holds unless an event changes it.
    always_comb begin
        w_state_nxt    = r_state;
        w_fcnt_nxt     = r_fcnt;
        w_load_nxt     = 1'b0;
        w_load_val_nxt = r_load_val;
        w_flush_nxt    = r_flush;
        w_irq_ack_nxt  = 1'b0;
        w_epc_nxt      = r_epc;
        w_irq_en_nxt   = r_irq_en;
        w_accept       = 1'b0;
        w_target       = r_load_val;

        unique case (r_state)
            RUN: begin
                // Priority: enabled irq > eret > jump > taken branch.
                if (irq && r_irq_en) begin
                    w_accept      = 1'b1;
                    w_target      = IRQ_VECTOR;
                    w_epc_nxt     = ex_pc;
                    w_irq_en_nxt  = 1'b0;
                    w_irq_ack_nxt = 1'b1;
                end else if (eret) begin
                    w_accept     = 1'b1;
                    w_target     = r_epc;
                    w_irq_en_nxt = 1'b1;
                end else if (jmp_valid) begin
                    w_accept = 1'b1;
                    w_target = jmp_target;
                end else if (br_valid && br_taken) begin
                    w_accept = 1'b1;
                    w_target = br_target;
                end

                if (w_accept) begin
                    w_load_nxt     = 1'b1;
                    w_load_val_nxt = w_target;
                    w_flush_nxt    = 1'b1;
                    w_fcnt_nxt     = FCNT_INIT;
                    w_state_nxt    = FLUSH;
                end
            end

            FLUSH: begin
                // Requests here come from squashed instructions and are
                // dropped; a held irq is picked up once back in RUN.
                w_fcnt_nxt = r_fcnt - 4'd1;
                if (r_fcnt == 4'd1) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = RUN;
                end
            end

            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign load     = r_load;
    assign load_val = r_load_val;
    assign flush    = r_flush;
    assign irq_ack  = r_irq_ack;
    assign epc      = r_epc;
    assign irq_en   = r_irq_en;

endmodule

// File: tb/tb_pc_redirect.sv
// -----------------------------------------------------------------------------
// Bench for pc_redirect. Two instances share the stimulus: one with the
// default 2-cycle flush window and one with a 4-cycle window. A behavioural
// model tracks, per instance, the edge index of the last accepted redirect
// and derives load/flush/irq_ack from distances in edges.
// -----------------------------------------------------------------------------
module tb_pc_redirect;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'd0;
    logic        eret = 1'b0;
    logic        irq = 1'b0;

    logic        ld [2];
    logic [31:0] lv [2];
    logic        fl [2];
    logic        ak [2];
    logic [31:0] ep [2];
    logic        en [2];

    always #5 clk = ~clk;

    pc_redirect #(.FLUSH_CYCLES(2), .IRQ_VECTOR(32'h0000_0100)) u_dut2 (
        .clk(clk), .reset(reset), .ex_pc(ex_pc),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .eret(eret), .irq(irq),
        .load(ld[0]), .load_val(lv[0]), .flush(fl[0]), .irq_ack(ak[0]),
        .epc(ep[0]), .irq_en(en[0])
    );

    pc_redirect #(.FLUSH_CYCLES(4), .IRQ_VECTOR(32'h0000_0100)) u_dut4 (
        .clk(clk), .reset(reset), .ex_pc(ex_pc),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .eret(eret), .irq(irq),
        .load(ld[1]), .load_val(lv[1]), .flush(fl[1]), .irq_ack(ak[1]),
        .epc(ep[1]), .irq_en(en[1])
    );

    // ---------------- checking bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    localparam int FC [2] = '{2, 4};
    localparam logic [31:0] VEC = 32'h0000_0100;

    int          m_edge [2]    = '{0, 0};
    int          m_last [2]    = '{-100, -100};
    bit          m_wasirq [2]  = '{0, 0};
    logic [31:0] m_val [2]     = '{32'd0, 32'd0};
    logic [31:0] m_epc [2]     = '{32'd0, 32'd0};
    bit          m_en [2]      = '{1, 1};

    task automatic model_reset(input int k);
        m_edge[k]   = 0;
        m_last[k]   = -100;
        m_wasirq[k] = 1'b0;
        m_val[k]    = 32'd0;
        m_epc[k]    = 32'd0;
        m_en[k]     = 1'b1;
    endtask

    task automatic model_step(input int k);
        m_edge[k]++;
        // A new request is only looked at once the previous window plus one
        // edge has elapsed.
        if (m_edge[k] - m_last[k] > FC[k]) begin
            if (irq && m_en[k]) begin
                m_last[k] = m_edge[k]; m_wasirq[k] = 1'b1;
                m_val[k] = VEC; m_epc[k] = ex_pc; m_en[k] = 1'b0;
            end else if (eret) begin
                m_last[k] = m_edge[k]; m_wasirq[k] = 1'b0;
                m_val[k] = m_epc[k]; m_en[k] = 1'b1;
            end else if (jmp_valid) begin
                m_last[k] = m_edge[k]; m_wasirq[k] = 1'b0;
                m_val[k] = jmp_target;
            end else if (br_valid && br_taken) begin
                m_last[k] = m_edge[k]; m_wasirq[k] = 1'b0;
                m_val[k] = br_target;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            for (int k = 0; k < 2; k++) begin
                automatic int  d     = m_edge[k] - m_last[k];
                automatic bit  e_ld  = (d == 0);
                automatic bit  e_fl  = (d >= 0) && (d < FC[k]);
                automatic bit  e_ak  = e_ld && m_wasirq[k];
                chk($sformatf("model.load[%0d]", k),     32'(ld[k]), 32'(e_ld));
                chk($sformatf("model.flush[%0d]", k),    32'(fl[k]), 32'(e_fl));
                chk($sformatf("model.irq_ack[%0d]", k),  32'(ak[k]), 32'(e_ak));
                chk($sformatf("model.load_val[%0d]", k), lv[k], m_val[k]);
                chk($sformatf("model.epc[%0d]", k),      ep[k], m_epc[k]);
                chk($sformatf("model.irq_en[%0d]", k),   32'(en[k]), 32'(m_en[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_req();
        br_valid = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        eret = 1'b0;
    endtask

    initial begin
        // Reset asserted mid-cycle; outputs must settle without a clock edge.
        tick(); tick();
        #3 reset = 1'b1;
        #1;
        chk("rst.load",     32'(ld[0]), 32'd0);
        chk("rst.load_val", lv[0], 32'd0);
        chk("rst.flush",    32'(fl[0]), 32'd0);
        chk("rst.irq_ack",  32'(ak[0]), 32'd0);
        chk("rst.epc",      ep[0], 32'd0);
        chk("rst.irq_en",   32'(en[0]), 32'd1);
        tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Idle: nothing happens.
        idle(10);
        chk("idle.load",  32'(ld[0]), 32'd0);
        chk("idle.flush", 32'(fl[0]), 32'd0);

        // Taken branch.
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick();
        clear_req();
        chk("br.load",     32'(ld[0]), 32'd1);
        chk("br.load_val", lv[0], 32'h40);
        chk("br.flush0",   32'(fl[0]), 32'd1);
        tick();
        chk("br.load_off", 32'(ld[0]), 32'd0);
        chk("br.flush1",   32'(fl[0]), 32'd1);
        tick();
        chk("br.flush_end", 32'(fl[0]), 32'd0);
        idle(4);

        // Not-taken branch: no activity.
        br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h77;
        tick();
        clear_req();
        chk("nt.load",     32'(ld[0]), 32'd0);
        chk("nt.flush",    32'(fl[0]), 32'd0);
        chk("nt.load_val", lv[0], 32'h40);
        idle(2);

        // Jump beats branch; a jump inside the window is ignored.
        jmp_valid = 1'b1; jmp_target = 32'h80;
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick();
        clear_req();
        chk("pri.load_val", lv[0], 32'h80);
        jmp_valid = 1'b1; jmp_target = 32'h200;
        tick();
        clear_req();
        chk("pri.ignored_load", 32'(ld[0]), 32'd0);
        chk("pri.ignored_val",  lv[0], 32'h80);
        idle(5);

        // Interrupt round trip.
        ex_pc = 32'h1C; irq = 1'b1;
        tick();
        chk("irq.load_val", lv[0], 32'h100);
        chk("irq.ack",      32'(ak[0]), 32'd1);
        chk("irq.epc",      ep[0], 32'h1C);
        chk("irq.en",       32'(en[0]), 32'd0);
        tick();
        chk("irq.ack_off",  32'(ak[0]), 32'd0);
        idle(6);
        chk("irq.no_reentry", 32'(ld[0]), 32'd0);
        irq = 1'b0; eret = 1'b1;
        tick();
        clear_req();
        chk("eret.load_val", lv[0], 32'h1C);
        chk("eret.en",       32'(en[0]), 32'd1);
        idle(6);

        // Deferred irq: raised during the window, taken at the first RUN edge.
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h300;
        tick();
        clear_req();
        chk("def.load_a", 32'(ld[0]), 32'd1);
        ex_pc = 32'h24; irq = 1'b1;
        tick();
        chk("def.wait1", 32'(ld[0]), 32'd0);
        tick();
        chk("def.wait2", 32'(ld[0]), 32'd0);
        tick();
        irq = 1'b0;
        chk("def.load_b", 32'(ld[0]), 32'd1);
        chk("def.val_b",  lv[0], 32'h100);
        chk("def.ack_b",  32'(ak[0]), 32'd1);
        chk("def.epc_b",  ep[0], 32'h24);
        idle(6);
        eret = 1'b1;
        tick();
        clear_req();
        idle(6);

        // Reset in the second cycle of a 4-cycle window.
        ex_pc = 32'h2C; irq = 1'b1;
        tick();
        irq = 1'b0;
        idle(6);
        chk("mid.pre_epc", ep[1], 32'h2C);
        chk("mid.pre_en",  32'(en[1]), 32'd0);
        jmp_valid = 1'b1; jmp_target = 32'h500;
        tick();
        clear_req();
        chk("mid.load", 32'(ld[1]), 32'd1);
        tick();
        chk("mid.flush2", 32'(fl[1]), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("mid.flush",    32'(fl[1]), 32'd0);
        chk("mid.load_rst", 32'(ld[1]), 32'd0);
        chk("mid.epc",      ep[1], 32'd0);
        chk("mid.irq_en",   32'(en[1]), 32'd1);
        chk("mid.load_val", lv[1], 32'd0);
        tick();
        reset = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Control-flow redirect stage sitting directly upstream of the program counter. It collects branch, jump, interrupt and return-from-interrupt requests from the execute stage, arbitrates them, and drives the counter's `load`/`load_val` inputs with a registered one-cycle load pulse. It also raises a pipeline `flush` window of fixed length and holds the exception PC and interrupt-enable state.

## Interface

- `FLUSH_CYCLES`, default 2: cycles `flush` stays high per redirect; legal range 1..15.
- `IRQ_VECTOR`, default 32'h0000_0100: interrupt entry address.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ex_pc`  in  32  address of the instruction in execute; saved to `epc` on interrupt entry.
- `br_valid`  in  1  conditional branch resolved this cycle.
- `br_taken`  in  1  branch outcome; meaningful only with `br_valid`.
- `br_target`  in  32  branch target address.
- `jmp_valid`  in  1  unconditional jump this cycle.
- `jmp_target`  in  32  jump target address.
- `eret`  in  1  return-from-interrupt this cycle.
- `irq`  in  1  level-sensitive interrupt request; held by source until acknowledged.
- `load`  out  1  to counter `load`; one-cycle pulse.
- `load_val`  out  32  to counter `load_val`; valid while `load` is high.
- `flush`  out  1  squash younger pipeline stages.
- `irq_ack`  out  1  one-cycle pulse on interrupt entry.
- `epc`  out  32  saved exception PC.
- `irq_en`  out  1  interrupts enabled.

## Operation

- Two states: RUN, FLUSH. A 4-bit down-counter `fcnt` tracks FLUSH length.
- Requests are sampled only at rising edges where state is RUN. In FLUSH, `br_*`, `jmp_*`, `eret` are ignored (they come from squashed instructions). `irq` is level-sensitive, so it is serviced once back in RUN.
- Priority in RUN, highest first:
  1. `irq && irq_en`: target `IRQ_VECTOR`; `epc<=ex_pc`; `irq_en<=0`; `irq_ack` pulses.
  2. `eret`: target `epc`; `irq_en<=1`.
  3. `jmp_valid`: target `jmp_target`.
  4. `br_valid && br_taken`: target `br_target`.
- `br_valid && !br_taken` or no request means no action. The state stays RUN and `load`, `flush`, `irq_ack` are 0.
- On an accepted request: `load<=1`, `load_val<=target`, `flush<=1`, `fcnt<=FLUSH_CYCLES`, state<=FLUSH. All outputs are registered; there are no combinational input-to-output paths.
- In FLUSH, at each edge: `load<=0`, `irq_ack<=0`, `fcnt<=fcnt-1`. At the edge where `fcnt==1`: `flush<=0` and state<=RUN.
- `load_val` holds its last target when `load` is low.
- Simultaneous `irq` and `eret` with `irq_en=1`: `irq` wins; `eret` is dropped.
- `eret` while `irq_en` is already 1: still redirects to `epc`; `irq_en` stays 1.
- Addresses pass through unmodified, with no alignment or width adjustment. Wrap-around of the counter is the counter's concern.

## Timing

- Reset (asynchronous, any time, including mid-FLUSH): state=RUN, `fcnt=0`, `load=0`, `load_val=0`, `flush=0`, `irq_ack=0`, `epc=0`, `irq_en=1`.
- Request accepted at edge E: `load`, `irq_ack` and `flush` are high in cycle E..E+1. The counter's `count` equals the target after edge E+1.
- `flush` is high for exactly `FLUSH_CYCLES` consecutive cycles, starting at edge E. The next request can be accepted at edge E+FLUSH_CYCLES+1.
- Redirect throughput: at most one per `FLUSH_CYCLES+1` cycles.
- `epc` and `irq_en` update at edge E and are stable afterward.

## Test plan

- Reset then idle: assert `reset` mid-cycle. All outputs go to reset values immediately, `irq_en=1`. No requests for 10 cycles: `load`, `flush` stay 0.
- Taken branch: `br_valid=1`, `br_taken=1`, `br_target=32'h40` for one cycle. Next cycle `load=1`, `load_val=32'h40`. `flush` high for 2 cycles, then low. Not-taken branch gives no activity.
- Priority: `jmp_valid` (target 32'h80) and taken branch (target 32'h40) in the same cycle gives `load_val=32'h80`. A jump asserted during the FLUSH window is ignored.
- Interrupt round-trip: `irq=1`, `ex_pc=32'h1C` gives `load_val=32'h100`, `irq_ack` pulse, `epc=32'h1C`, `irq_en=0`. While `irq` is still high, no re-entry. `eret` gives `load_val=32'h1C`, `irq_en=1`.
- Deferred irq: raise `irq` during FLUSH. It is taken at the first RUN edge, i.e. `load` goes high exactly `FLUSH_CYCLES+1` cycles after the previous `load` pulse.
- Reset mid-FLUSH with `FLUSH_CYCLES=4`: assert `reset` in flush cycle 2. `flush` and `load` drop immediately, and `epc` and `irq_en` return to reset values.
